// File: rtl/radar_timing_pkg.sv
// Shared types for the radar timing path: waveform profile layout, its power-on
// default and the CPI scheduler state encoding.
package radar_timing_pkg;

    typedef struct packed {
        logic [31:0] cpi_delay;
        logic [15:0] pri_period;
        logic [7:0]  pri_num;
        logic [7:0]  pri_pulse_width;
        logic [15:0] start_sample;
        logic [15:0] sample_length;
        logic [7:0]  wave_code;
        logic        first_chirp_dis;
    } prof_t;

    localparam prof_t PROF_DEFAULT = '{
        cpi_delay:       32'd750,
        pri_period:      16'd5275,
        pri_num:         8'd32,
        pri_pulse_width: 8'd50,
        start_sample:    16'd1000,
        sample_length:   16'd4125,
        wave_code:       8'd0,
        first_chirp_dis: 1'b0
    };

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

endpackage

// File: rtl/wave_prof_ram.sv
// Waveform profile table: synchronous write, asynchronous read, every entry
// returns to the default profile on reset.
module wave_prof_ram
    import radar_timing_pkg::*;
#(
    parameter int unsigned N_PROF = 4,
    parameter int unsigned IW     = 2
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  prof_t         wr_data,
    input  logic [IW-1:0] rd_idx,
    output prof_t         rd_data
);

    // Full power-of-two depth keeps indexing in range; slots >= N_PROF never take writes.
    localparam int unsigned Depth = 1 << IW;

    prof_t mem_q [Depth];
    prof_t mem_d [Depth];

    always_comb begin
        mem_d = mem_q;
        if (wr_en && (32'(wr_idx) < N_PROF)) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= PROF_DEFAULT;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/wave_sched.sv
// CPI-level waveform scheduler: steps through the profile table on CPIE and gates
// the timing generator run enable so it only starts and stops on CPI boundaries.
module wave_sched
    import radar_timing_pkg::*;
#(
    parameter int unsigned N_PROF = 4,
    localparam int unsigned IW    = $clog2(N_PROF)
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          cfg_wr,
    input  logic [IW-1:0] cfg_idx,
    input  logic [104:0]  cfg_prof,
    input  logic          start,
    input  logic          stop,
    input  logic [IW:0]   seq_len,
    input  logic          loop_en,
    input  logic [15:0]   cpi_limit,
    input  logic          cpie,
    output logic [31:0]   cpi_delay,
    output logic [15:0]   pri_period,
    output logic [7:0]    pri_num,
    output logic [7:0]    pri_pulse_width,
    output logic [15:0]   start_sample,
    output logic [15:0]   sample_length,
    output logic [7:0]    wave_code,
    output logic          first_chirp_disable,
    output logic          tmg_run,
    output logic          busy,
    output logic [IW-1:0] prof_idx,
    output logic [15:0]   cpi_cnt,
    output logic          done,
    output logic          cfg_err
);

    state_t        state_q, state_d;
    logic [1:0]    arm_cnt_q, arm_cnt_d;
    logic          stop_q, stop_d;
    logic [IW:0]   seq_len_q, seq_len_d;
    logic          loop_en_q, loop_en_d;
    logic [15:0]   cpi_limit_q, cpi_limit_d;
    prof_t         prof_q, prof_d;
    logic [IW-1:0] prof_idx_q, prof_idx_d;
    logic [15:0]   cpi_cnt_q, cpi_cnt_d;
    logic          tmg_run_q, tmg_run_d;
    logic          done_q, done_d;
    logic          cfg_err_q, cfg_err_d;
    logic          cpie_q, cpie_qq;

    logic          rise, fall;
    logic          seq_valid;
    logic [IW:0]   idx_plus1;
    logic [15:0]   cnt_inc;
    logic          limit_hit, more, run_end;
    logic          load;
    logic [IW-1:0] rd_idx;
    prof_t         rd_prof;

    wave_prof_ram #(
        .N_PROF (N_PROF),
        .IW     (IW)
    ) u_ram (
        .sys_clk (sys_clk),
        .rst     (rst),
        .wr_en   (cfg_wr),
        .wr_idx  (cfg_idx),
        .wr_data (prof_t'(cfg_prof)),
        .rd_idx  (rd_idx),
        .rd_data (rd_prof)
    );

    assign rise      = cpie_q & ~cpie_qq;
    assign fall      = ~cpie_q & cpie_qq;
    assign seq_valid = (seq_len != '0) && (32'(seq_len) <= N_PROF);
    assign idx_plus1 = {1'b0, prof_idx_q} + (IW+1)'(1);
    assign cnt_inc   = cpi_cnt_q + 16'd1;
    assign limit_hit = (cpi_limit_q != '0) && (cnt_inc == cpi_limit_q);
    assign more      = idx_plus1 < seq_len_q;
    assign run_end   = stop_q || limit_hit || (!more && !loop_en_q);

    // Kept apart from the FSM block so the table read path does not loop through it.
    always_comb begin
        load   = 1'b0;
        rd_idx = '0;
        if (state_q == IDLE) begin
            load = start && seq_valid;
        end else if ((state_q == RUN) && rise && !run_end) begin
            load = 1'b1;
            if (more) begin
                rd_idx = idx_plus1[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        arm_cnt_d   = arm_cnt_q;
        stop_d      = stop_q;
        seq_len_d   = seq_len_q;
        loop_en_d   = loop_en_q;
        cpi_limit_d = cpi_limit_q;
        prof_d      = prof_q;
        prof_idx_d  = prof_idx_q;
        cpi_cnt_d   = cpi_cnt_q;
        tmg_run_d   = tmg_run_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (seq_valid) begin
                        seq_len_d   = seq_len;
                        loop_en_d   = loop_en;
                        cpi_limit_d = cpi_limit;
                        cpi_cnt_d   = '0;
                        arm_cnt_d   = '0;
                        stop_d      = stop;
                        state_d     = ARM;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ARM: begin
                if (stop) stop_d = 1'b1;
                // Three cycles lets the generator's parameter sampling settle.
                if (arm_cnt_q == 2'd2) begin
                    tmg_run_d = 1'b1;
                    state_d   = RUN;
                end else begin
                    arm_cnt_d = arm_cnt_q + 2'd1;
                end
            end
            RUN: begin
                if (stop) stop_d = 1'b1;
                if (rise) begin
                    cpi_cnt_d = cnt_inc;
                    if (run_end) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fall) begin
                    tmg_run_d = 1'b0;
                    done_d    = 1'b1;
                    stop_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            prof_d     = rd_prof;
            prof_idx_d = rd_idx;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            arm_cnt_q   <= '0;
            stop_q      <= 1'b0;
            seq_len_q   <= '0;
            loop_en_q   <= 1'b0;
            cpi_limit_q <= '0;
            prof_q      <= PROF_DEFAULT;
            prof_idx_q  <= '0;
            cpi_cnt_q   <= '0;
            tmg_run_q   <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            cpie_q      <= 1'b0;
            cpie_qq     <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_cnt_q   <= arm_cnt_d;
            stop_q      <= stop_d;
            seq_len_q   <= seq_len_d;
            loop_en_q   <= loop_en_d;
            cpi_limit_q <= cpi_limit_d;
            prof_q      <= prof_d;
            prof_idx_q  <= prof_idx_d;
            cpi_cnt_q   <= cpi_cnt_d;
            tmg_run_q   <= tmg_run_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            cpie_q      <= cpie;
            cpie_qq     <= cpie_q;
        end
    end

    assign cpi_delay           = prof_q.cpi_delay;
    assign pri_period          = prof_q.pri_period;
    assign pri_num             = prof_q.pri_num;
    assign pri_pulse_width     = prof_q.pri_pulse_width;
    assign start_sample        = prof_q.start_sample;
    assign sample_length       = prof_q.sample_length;
    assign wave_code           = prof_q.wave_code;
    assign first_chirp_disable = prof_q.first_chirp_dis;
    assign tmg_run             = tmg_run_q;
    assign busy                = (state_q != IDLE);
    assign prof_idx            = prof_idx_q;
    assign cpi_cnt             = cpi_cnt_q;
    assign done                = done_q;
    assign cfg_err             = cfg_err_q;

endmodule

// File: tb/tb_wave_sched.sv
// Scoreboard bench for wave_sched: stimulus pushes time-stamped expectations from a
// CPI-level model; a negedge monitor pops and compares them against the outputs.
module tb_wave_sched;
    import radar_timing_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_wr = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [104:0]  cfg_prof = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [IW:0]   seq_len = '0;
    logic          loop_en = 1'b0;
    logic [15:0]   cpi_limit = '0;
    logic          cpie = 1'b0;
    logic [31:0]   cpi_delay;
    logic [15:0]   pri_period, start_sample, sample_length, cpi_cnt;
    logic [7:0]    pri_num, pri_pulse_width, wave_code;
    logic          first_chirp_disable, tmg_run, busy, done, cfg_err;
    logic [IW-1:0] prof_idx;

    wave_sched #(.N_PROF(N)) dut (
        .sys_clk             (sys_clk),
        .rst                 (rst),
        .cfg_wr              (cfg_wr),
        .cfg_idx             (cfg_idx),
        .cfg_prof            (cfg_prof),
        .start               (start),
        .stop                (stop),
        .seq_len             (seq_len),
        .loop_en             (loop_en),
        .cpi_limit           (cpi_limit),
        .cpie                (cpie),
        .cpi_delay           (cpi_delay),
        .pri_period          (pri_period),
        .pri_num             (pri_num),
        .pri_pulse_width     (pri_pulse_width),
        .start_sample        (start_sample),
        .sample_length       (sample_length),
        .wave_code           (wave_code),
        .first_chirp_disable (first_chirp_disable),
        .tmg_run             (tmg_run),
        .busy                (busy),
        .prof_idx            (prof_idx),
        .cpi_cnt             (cpi_cnt),
        .done                (done),
        .cfg_err             (cfg_err)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        string       name;
        prof_t       prof;
        logic [21:0] st;
    } exp_t;

    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;

    // Reference model: table contents and what should currently be presented.
    prof_t tbl [N];
    prof_t pres_prof;
    int    pres_idx;
    int    pres_cnt;

    function automatic prof_t dflt();
        prof_t p;
        p.cpi_delay       = 32'd750;
        p.pri_period      = 16'd5275;
        p.pri_num         = 8'd32;
        p.pri_pulse_width = 8'd50;
        p.start_sample    = 16'd1000;
        p.sample_length   = 16'd4125;
        p.wave_code       = 8'd0;
        p.first_chirp_dis = 1'b0;
        return p;
    endfunction

    function automatic prof_t rand_prof();
        prof_t p;
        p.cpi_delay       = $urandom;
        p.pri_period      = 16'($urandom);
        p.pri_num         = 8'($urandom);
        p.pri_pulse_width = 8'($urandom);
        p.start_sample    = 16'($urandom);
        p.sample_length   = 16'($urandom);
        p.wave_code       = 8'($urandom);
        p.first_chirp_dis = 1'($urandom);
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) tbl[i] = dflt();
        pres_prof = dflt();
        pres_idx  = 0;
        pres_cnt  = 0;
    endtask

    task automatic push_exp(input int at, input string nm, input logic run, input logic bsy,
                            input logic dn, input logic err);
        exp_t e;
        logic [IW-1:0] ix;
        logic [15:0]   cn;
        ix     = pres_idx[IW-1:0];
        cn     = pres_cnt[15:0];
        e.at   = at;
        e.name = nm;
        e.prof = pres_prof;
        e.st   = {run, bsy, dn, err, ix, cn};
        exp_q.push_back(e);
    endtask

    always @(negedge sys_clk) begin
        prof_t       got_p;
        logic [21:0] got_s;
        exp_t        e;
        got_p = {cpi_delay, pri_period, pri_num, pri_pulse_width, start_sample, sample_length,
                 wave_code, first_chirp_disable};
        got_s = {tmg_run, busy, done, cfg_err, prof_idx, cpi_cnt};
        while (exp_q.size() != 0 && exp_q[0].at < cyc) begin
            e = exp_q.pop_front();
            n_fail++;
            $display("FAIL %s: check at cycle %0d skipped (now %0d)", e.name, e.at, cyc);
        end
        if (exp_q.size() != 0 && exp_q[0].at == cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_s !== e.st) begin
                n_fail++;
                $display("FAIL %s_status @%0d: got run/busy/done/err/idx/cnt=%h want %h",
                         e.name, cyc, got_s, e.st);
            end
            n_cmp++;
            if (got_p !== e.prof) begin
                n_fail++;
                $display("FAIL %s_profile @%0d: got %h want %h", e.name, cyc, got_p, e.prof);
            end
        end else if (done === 1'b1 || cfg_err === 1'b1) begin
            n_fail++;
            $display("FAIL unexpected_pulse @%0d: done=%b cfg_err=%b want 0/0", cyc, done, cfg_err);
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic write_entry(input int idx, input prof_t p);
        cfg_wr   = 1'b1;
        cfg_idx  = idx[IW-1:0];
        cfg_prof = p;
        tbl[idx] = p;
        tick();
        cfg_wr   = 1'b0;
    endtask

    // stop_cpi: 0 none, 1 with the start pulse, k>1 mid-CPI k.
    // wr_cpi: rewrite the active entry during CPI k. sc_cpi: rewrite the entry loaded at CPI k's end.
    task automatic do_run(input int sl, input bit lp, input int lim, input int stop_cpi,
                          input int wr_cpi, input int sc_cpi);
        int n, s, r, f, nxt, low;
        prof_t p;
        n = 1000;
        if (lim != 0) n = lim;
        if (!lp && sl < n) n = sl;
        if (stop_cpi > 0 && stop_cpi < n) n = stop_cpi;
        s         = cyc;
        seq_len   = sl[IW:0];
        loop_en   = lp;
        cpi_limit = lim[15:0];
        start     = 1'b1;
        stop      = (stop_cpi == 1);
        pres_prof = tbl[0];
        pres_idx  = 0;
        pres_cnt  = 0;
        push_exp(s + 1, "arm", 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp(s + 3, "arm_end", 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp(s + 4, "run_start", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        stop  = 1'b0;
        idle(3);
        for (int k = 1; k <= n; k++) begin
            low = $urandom_range(8, 16);
            for (int c = 0; c < low; c++) begin
                if (k == stop_cpi && k > 1 && c == low / 2) stop = 1'b1;
                if (k == wr_cpi && c == 2) begin
                    p        = rand_prof();
                    cfg_wr   = 1'b1;
                    cfg_idx  = pres_idx[IW-1:0];
                    cfg_prof = p;
                    tbl[pres_idx] = p;
                end
                tick();
                stop   = 1'b0;
                cfg_wr = 1'b0;
            end
            r    = cyc;
            cpie = 1'b1;
            push_exp(r + 1, "pre_load", 1'b1, 1'b1, 1'b0, 1'b0);
            pres_cnt = k;
            nxt = k % sl;
            if (k < n) begin
                pres_prof = tbl[nxt];
                pres_idx  = nxt;
            end
            push_exp(r + 2, (k < n) ? "load" : "last_cpi", 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            if (k == sc_cpi && k < n) begin
                p        = rand_prof();
                cfg_wr   = 1'b1;
                cfg_idx  = nxt[IW-1:0];
                cfg_prof = p;
                tbl[nxt] = p;
            end
            tick();
            cfg_wr = 1'b0;
            idle($urandom_range(3, 6));
            f    = cyc;
            cpie = 1'b0;
            if (k == n) begin
                push_exp(f + 1, "drain", 1'b1, 1'b1, 1'b0, 1'b0);
                push_exp(f + 2, "done", 1'b0, 1'b0, 1'b1, 1'b0);
                push_exp(f + 3, "idle", 1'b0, 1'b0, 1'b0, 1'b0);
                idle(4);
            end
        end
    endtask

    task automatic bad_start(input int sl);
        int s;
        s       = cyc;
        seq_len = sl[IW:0];
        start   = 1'b1;
        push_exp(s + 1, "cfg_err", 1'b0, 1'b0, 1'b0, 1'b1);
        push_exp(s + 2, "err_clear", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        idle(3);
    endtask

    task automatic reset_mid_run();
        int s, r, c;
        s         = cyc;
        seq_len   = 3'd2;
        loop_en   = 1'b1;
        cpi_limit = 16'd0;
        start     = 1'b1;
        pres_prof = tbl[0];
        pres_idx  = 0;
        pres_cnt  = 0;
        push_exp(s + 4, "rr_run", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        idle(10);
        r    = cyc;
        cpie = 1'b1;
        pres_prof = tbl[1];
        pres_idx  = 1;
        pres_cnt  = 1;
        push_exp(r + 2, "rr_load", 1'b1, 1'b1, 1'b0, 1'b0);
        idle(4);
        c = cyc;
        model_reset();
        push_exp(c, "rst_hold0", 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(c + 1, "rst_hold1", 1'b0, 1'b0, 1'b0, 1'b0);
        rst  = 1'b1;
        cpie = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        idle(2);
    endtask

    initial begin
        prof_t p;
        int sl, lim, stp;
        bit lp;
        model_reset();
        push_exp(1, "reset0", 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(2, "reset1", 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        rst = 1'b0;
        idle(2);

        do_run(1, 1'b0, 0, 0, 0, 0);

        for (int i = 0; i < 3; i++) begin
            p = rand_prof();
            p.pri_period = 16'(1000 * (i + 1));
            write_entry(i, p);
        end
        do_run(3, 1'b1, 7, 0, 0, 0);

        stop = 1'b1;
        tick();
        stop = 1'b0;
        idle(2);
        do_run(3, 1'b1, 0, 2, 0, 0);
        do_run(2, 1'b1, 0, 1, 0, 0);

        bad_start(0);
        bad_start(N + 1);

        do_run(2, 1'b1, 5, 0, 2, 3);
        do_run(1, 1'b1, 3, 0, 1, 0);

        repeat (6) begin
            sl  = $urandom_range(1, N);
            lp  = 1'($urandom);
            lim = $urandom_range(0, 6);
            stp = $urandom_range(0, 4);
            if (lp && lim == 0 && stp == 0) lim = 5;
            do_run(sl, lp, lim, stp, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        reset_mid_run();
        do_run(N, 1'b0, 0, 0, 0, 0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_queue: %0d checks left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
